uart_frame_rx: RTL and testbench

- Consumes the received-byte stream from uart_controller (pc_data_o / pc_valid_o / pc_ready_i).
- Parses framed sort requests of the form SOF, LEN, LEN payload bytes, then an XOR checksum byte.
- Buffers the payload and releases it to the sorter only after the checksum passes. Bad frames are dropped and flagged.

---
 rtl/uart_frame_pkg.sv | 6 +
 rtl/uart_frame_rx_frame_buf.sv | 18 +
 rtl/uart_frame_rx.sv | 166 ++++++++++++++++
 tb/tb_uart_frame_rx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared state/error encodings and the default start-of-frame marker.
package uart_frame_pkg;
  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHECK, DRAIN} frame_state_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TIMEOUT} frame_err_e;
  localparam logic [7:0] SOF_DEFAULT = 8'hA5;
endpackage

// File: rtl/uart_frame_rx_frame_buf.sv
// frame_buf: simple dual-port payload RAM, one write port and one synchronous read port.
module frame_buf #(
  parameter int DEPTH = 64,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: parses SOF/LEN/payload/XOR-checksum frames and releases checked payloads.
// Define UART_FRAME_RX_TIMEOUT_EN to abort frames after TIMEOUT_CYCLES idle cycles.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN        = 64,
  parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data_i,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  output logic [7:0] m_data_o,
  output logic       m_valid_o,
  output logic       m_last_o,
  input  logic       m_ready_i,
  output logic       frame_ok_o,
  output logic       frame_err_o,
  output logic [1:0] err_code_o,
  output logic       busy_o
);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  frame_state_e  state_q, state_d;
  frame_err_e    err_code_q, err_code_d;
  logic [7:0]    len_q, len_d, csum_q, csum_d, m_data_q, m_data_d, rd_data;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          m_valid_q, m_valid_d, m_last_q, m_last_d, done_q, done_d;
  logic          frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
  logic          acc, we, ld;
`ifdef UART_FRAME_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  assign s_ready_o   = state_q != DRAIN;
  assign busy_o      = state_q != IDLE;
  assign acc         = s_valid_i && s_ready_o;
  assign m_data_o    = m_data_q;
  assign m_valid_o   = m_valid_q;
  assign m_last_o    = m_last_q;
  assign frame_ok_o  = frame_ok_q;
  assign frame_err_o = frame_err_q;
  assign err_code_o  = err_code_q;

  // rd_ptr_d drives the RAM address, so rd_data always holds buf[rd_ptr_q].
  frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk(clk), .we(we), .waddr(wr_ptr_q), .wdata(s_data_i),
    .raddr(rd_ptr_d), .rdata(rd_data)
  );

  always_comb begin
    state_d     = state_q;
    err_code_d  = err_code_q;
    len_d       = len_q;
    csum_d      = csum_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    done_d      = done_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    we          = 1'b0;
    ld          = 1'b0;
    case (state_q)
      IDLE: if (acc && s_data_i == SOF_BYTE) state_d = LEN;
      LEN: if (acc) begin
        if (s_data_i == 8'd0 || {24'd0, s_data_i} > MAX_LEN) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_LEN;
          state_d     = IDLE;
        end else begin
          len_d    = s_data_i;
          csum_d   = s_data_i;
          wr_ptr_d = '0;
          state_d  = PAYLOAD;
        end
      end
      PAYLOAD: if (acc) begin
        we       = 1'b1;
        csum_d   = csum_q ^ s_data_i;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (8'(wr_ptr_q) == len_q - 8'd1) state_d = CHECK;
      end
      CHECK: begin
        rd_ptr_d = '0;
        done_d   = 1'b0;
        if (acc) begin
          frame_ok_d  = s_data_i == csum_q;
          frame_err_d = s_data_i != csum_q;
          err_code_d  = s_data_i == csum_q ? err_code_q : ERR_CSUM;
          state_d     = s_data_i == csum_q ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        ld = !done_q && (!m_valid_q || m_ready_i);
        if (ld) begin
          m_data_d  = rd_data;
          m_last_d  = 8'(rd_ptr_q) == len_q - 8'd1;
          m_valid_d = 1'b1;
          rd_ptr_d  = rd_ptr_q + 1'b1;
          done_d    = m_last_d;
        end else if (m_valid_q && m_ready_i) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end
        if (m_valid_q && m_ready_i && m_last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef UART_FRAME_RX_TIMEOUT_EN
    tmo_d = '0;
    if (state_q inside {LEN, PAYLOAD, CHECK}) begin
      tmo_d = acc ? '0 : tmo_q + 1'b1;
      if (!acc && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        frame_err_d = 1'b1;
        err_code_d  = ERR_TIMEOUT;
        state_d     = IDLE;
        tmo_d       = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      err_code_q  <= ERR_NONE;
      len_q       <= '0;
      csum_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      done_q      <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_FRAME_RX_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      err_code_q  <= err_code_d;
      len_q       <= len_d;
      csum_q      <= csum_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      done_q      <= done_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
`ifdef UART_FRAME_RX_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed frames with hand-computed payloads, checksums and error codes.
module tb_uart_frame_rx;
  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] s_data_i = 8'h00;
  logic s_valid_i = 1'b0, m_ready_i = 1'b1;
  logic s_ready_o, m_valid_o, m_last_o, frame_ok_o, frame_err_o, busy_o;
  logic [7:0] m_data_o;
  logic [1:0] err_code_o;
  int n_cmp = 0, n_bad = 0, rmode = 0;
  int n_ok = 0, n_err = 0, viol = 0, n_vcyc = 0;
  logic [8:0] outq[$];
  logic [7:0] big[$];
  logic [7:0] bcs;

  always #5 clk = ~clk;

  uart_frame_rx #(.MAX_LEN(64), .SOF_BYTE(8'hA5), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i),
    .frame_ok_o(frame_ok_o), .frame_err_o(frame_err_o), .err_code_o(err_code_o), .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    m_ready_i = rmode == 0 ? 1'b1 : rmode == 1 ? !m_ready_i : 1'b0;
  end

  initial begin : mon
    logic held;
    logic [8:0] hv;
    held = 1'b0;
    hv = '0;
    forever begin
      @(negedge clk);
      if (!rst) held = 1'b0;
      else begin
        if (held && (!m_valid_o || {m_last_o, m_data_o} != hv)) viol++;
        held = m_valid_o && !m_ready_i;
        hv = {m_last_o, m_data_o};
        if (m_valid_o && m_ready_i) outq.push_back(hv);
        if (m_valid_o) n_vcyc++;
        if (m_valid_o && s_ready_o) viol++;
        if (frame_ok_o && frame_err_o) viol++;
        if (frame_ok_o) n_ok++;
        if (frame_err_o) n_err++;
      end
    end
  end

  task automatic clr();
    outq.delete();
    n_ok = 0;
    n_err = 0;
    viol = 0;
    n_vcyc = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    s_data_i = b;
    s_valid_i = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!s_ready_o && t < 300);
    if (!s_ready_o) chk("accept_bound", 0, 1);
    @(posedge clk);
    #1;
    s_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b[$]);
    foreach (b[i]) send_byte(b[i]);
  endtask

  task automatic wait_idle();
    int t = 0;
    repeat (3) @(negedge clk);
    while (busy_o && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("idle_bound", busy_o, 0);
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] d[$]);
    chk({tag, "_count"}, outq.size(), d.size());
    for (int i = 0; i < d.size() && i < outq.size(); i++)
      chk(tag, outq[i], {i == d.size() - 1, d[i]});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_s_ready", s_ready_o, 1);
    chk("rst_m_valid", m_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err_code", err_code_o, 0);
    chk("rst_pulses", {frame_ok_o, frame_err_o, m_last_o}, 0);
    rst = 1'b1;
    @(posedge clk);
    #2;
    clr();

    send_frame('{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30});
    send_byte(8'h03);
    @(negedge clk);
    chk("ok_pulse", frame_ok_o, 1);
    @(negedge clk);
    chk("first_valid", m_valid_o, 1);
    chk("drain_s_ready", s_ready_o, 0);
    wait_idle();
    expect_out("good", '{8'h10, 8'h20, 8'h30});
    chk("good_ok", n_ok, 1);
    chk("good_err", n_err, 0);
    chk("good_code", err_code_o, 0);
    chk("good_tput", n_vcyc, 3);
    chk("good_viol", viol, 0);
    clr();

    send_frame('{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h04});
    wait_idle();
    chk("csum_out", outq.size(), 0);
    chk("csum_err", n_err, 1);
    chk("csum_ok", n_ok, 0);
    chk("csum_code", err_code_o, 2);
    clr();
    send_frame('{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h03});
    wait_idle();
    expect_out("after_csum", '{8'h10, 8'h20, 8'h30});
    chk("after_csum_ok", n_ok, 1);
    chk("code_held", err_code_o, 2);
    clr();

    send_frame('{8'hA5, 8'h00});
    wait_idle();
    chk("len0_code", err_code_o, 1);
    chk("len0_err", n_err, 1);
    chk("len0_out", outq.size(), 0);
    clr();
    send_frame('{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h07});
    wait_idle();
    clr();
    send_frame('{8'hA5, 8'h41});
    wait_idle();
    chk("len65_code", err_code_o, 1);
    chk("len65_err", n_err, 1);
    chk("len65_out", outq.size(), 0);
    clr();

    big.delete();
    bcs = 8'h40;
    for (int i = 0; i < 64; i++) begin
      big.push_back(8'(i * 3 + 1));
      bcs ^= 8'(i * 3 + 1);
    end
    send_frame('{8'hA5, 8'h40});
    send_frame(big);
    send_byte(bcs);
    wait_idle();
    expect_out("max_len", big);
    chk("max_len_ok", n_ok, 1);
    clr();

    send_frame('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h13});
    wait_idle();
    expect_out("noise", '{8'hAA, 8'hBB});
    chk("noise_ok", n_ok, 1);
    chk("noise_err", n_err, 0);
    clr();

    rmode = 1;
    send_frame('{8'hA5, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h40});
    wait_idle();
    expect_out("bp", '{8'h11, 8'h22, 8'h33, 8'h44});
    chk("bp_stable", viol, 0);
    rmode = 0;
    clr();

    send_frame('{8'hA5, 8'h03, 8'h10});
    rst = 1'b0;
    #1;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_s_ready", s_ready_o, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    clr();
    send_frame('{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h03});
    wait_idle();
    expect_out("post_rst", '{8'h10, 8'h20, 8'h30});
    chk("post_rst_code", err_code_o, 0);
    clr();

    rmode = 2;
    send_frame('{8'hA5, 8'h01, 8'h77, 8'h76});
    for (int t = 0; t < 20 && !m_valid_o; t++) @(negedge clk);
    chk("stall_valid", m_valid_o, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_drop", m_valid_o, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    rmode = 0;
    clr();

`ifdef UART_FRAME_RX_TIMEOUT_EN
    send_frame('{8'hA5, 8'h03});
    for (int t = 0; t < 150 && n_err == 0; t++) @(negedge clk);
    chk("tmo_err", n_err, 1);
    chk("tmo_code", err_code_o, 3);
    chk("tmo_busy", busy_o, 0);
    clr();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
